// File: rtl/int2float_pkg.sv
// rtl/int2float_pkg.sv - shared sizing and configuration helpers for the int->mini-float converter
// Purpose: width helpers used by int2float_pipe and int2float_lzc.
//   out_w        : packed output width {sign?, exp, man}
//   lzc_w        : width of a leading-zero count able to represent 0..w
//   exp_range_ok : exponent field can encode every leading-one position of the input
package int2float_pkg;

  function automatic int out_w(input int signed_mode, input int exp_w, input int man_w);
    return ((signed_mode != 0) ? 1 : 0) + exp_w + man_w;
  endfunction

  function automatic int lzc_w(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic bit exp_range_ok(input int in_w, input int exp_w, input int man_w);
    return (in_w >= man_w + 1) && (((2 ** exp_w) - 1) >= (in_w - man_w));
  endfunction

endpackage

// File: rtl/int2float_lzc.sv
// rtl/int2float_lzc.sv - combinational leading-zero counter with all-zero flag
// Ports:
//   data  in  W   operand
//   count out CW  number of leading zeros (W when data is zero)
//   zero  out 1   data is all zeros
module int2float_lzc
  import int2float_pkg::*;
#(
  parameter int W  = 11,
  parameter int CW = lzc_w(W)
) (
  input  logic [W-1:0]  data,
  output logic [CW-1:0] count,
  output logic          zero
);

  // Scan upward so the highest set bit writes last and wins.
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (data[i]) count = CW'(W - 1 - i);
    end
  end

  assign zero = ~|data;

endmodule

// File: rtl/int2float_pipe.sv
// rtl/int2float_pipe.sv - 3-stage integer to mini-float converter with valid/ready handshake
// Build option: INT2FLOAT_ROUND_NEAREST_EN selects round-to-nearest-even with saturation;
//   when undefined the mantissa is truncated toward zero.
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready  input handshake, in_data IN_W-bit integer
//   out_valid / out_ready output handshake
//   out_data             {sign (SIGNED only), exp[EXP_W], man[MAN_W]}
//   out_inexact          nonzero bits were discarded, qualified by out_valid
module int2float_pipe
  import int2float_pkg::*;
#(
  parameter int IN_W   = 11,
  parameter int EXP_W  = 3,
  parameter int MAN_W  = 4,
  parameter int SIGNED = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [IN_W-1:0]                      in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [out_w(SIGNED,EXP_W,MAN_W)-1:0] out_data,
  output logic                                 out_inexact
);

  localparam int OUT_W = out_w(SIGNED, EXP_W, MAN_W);
  localparam int LZW   = lzc_w(IN_W);
  localparam int DW    = IN_W - MAN_W + 1;   // discarded bits plus two zero pad bits
`ifdef INT2FLOAT_ROUND_NEAREST_EN
  localparam int EN_W  = EXP_W + 1;          // room for the rounding carry
  localparam int EMAX  = (2 ** EXP_W) - 1;
`else
  localparam int EN_W  = EXP_W;
`endif

  if (!exp_range_ok(IN_W, EXP_W, MAN_W)) begin : g_cfg_err
    $error("int2float_pipe: EXP_W cannot encode every leading-one position of IN_W");
  end

  typedef struct packed {
    logic            valid;
    logic            sign;
    logic [IN_W-1:0] mag;
  } s1_t;

  typedef struct packed {
    logic            valid;
    logic            sign;
    logic            zero;
    logic [LZW-1:0]  lzc;
    logic [IN_W-1:0] norm;   // magnitude shifted so the leading one sits at the MSB
  } s2_t;

  s1_t s1, s1_nxt;
  s2_t s2, s2_nxt;

  logic rdy1, rdy2, rdy3;

  assign rdy3     = !out_valid | out_ready;
  assign rdy2     = !s2.valid | rdy3;
  assign rdy1     = !s1.valid | rdy2;
  assign in_ready = rdy1;

  // S1: sign/magnitude. The most negative input maps to 2**(IN_W-1), which still fits unsigned.
  logic neg;
  assign neg = (SIGNED != 0) && in_data[IN_W-1];

  always_comb begin
    s1_nxt.valid = in_valid;
    s1_nxt.sign  = neg;
    s1_nxt.mag   = neg ? -in_data : in_data;
  end

  // S2: leading-zero count and normalise.
  logic [LZW-1:0] lzc_c;
  logic           zero_c;

  int2float_lzc #(.W(IN_W), .CW(LZW)) u_lzc (
    .data  (s1.mag),
    .count (lzc_c),
    .zero  (zero_c)
  );

  always_comb begin
    s2_nxt.valid = s1.valid;
    s2_nxt.sign  = s1.sign;
    s2_nxt.zero  = zero_c;
    s2_nxt.lzc   = lzc_c;
    s2_nxt.norm  = s1.mag << lzc_c;
  end

  // S3: round and pack.
  logic [MAN_W-1:0] man_t;
  logic [DW-1:0]    disc;
  logic [EN_W-1:0]  exp_n;
  logic [EXP_W-1:0] exp_o;
  logic [MAN_W-1:0] man_o;
  logic             inex;
  logic [OUT_W-1:0] pack_c;
`ifdef INT2FLOAT_ROUND_NEAREST_EN
  logic             guard, sticky, rnd;
  logic [MAN_W:0]   man_sum;
  logic [EN_W-1:0]  exp_r;
`endif

  always_comb begin
    man_t = MAN_W'(s2.norm >> (IN_W - 1 - MAN_W));
    disc  = DW'({s2.norm, 2'b00});
    exp_n = EN_W'(IN_W - MAN_W) - EN_W'(s2.lzc);
`ifdef INT2FLOAT_ROUND_NEAREST_EN
    guard   = disc[DW-1];
    sticky  = |disc[DW-2:0];
    rnd     = guard & (sticky | man_t[0]);
    man_sum = {1'b0, man_t} + (MAN_W+1)'(rnd);
    exp_r   = exp_n + EN_W'(man_sum[MAN_W]);
`endif
    exp_o = '0;
    man_o = '0;
    inex  = 1'b0;
    if (s2.zero) begin
      exp_o = '0;
    end else if (s2.lzc > LZW'(IN_W - 1 - MAN_W)) begin
      // Leading one below MAN_W: stored as an exact subnormal.
      man_o = MAN_W'(s2.norm >> s2.lzc);
    end else begin
`ifdef INT2FLOAT_ROUND_NEAREST_EN
      if (exp_r > EN_W'(EMAX)) begin
        exp_o = '1;
        man_o = '1;
        inex  = 1'b1;
      end else begin
        exp_o = exp_r[EXP_W-1:0];
        man_o = man_sum[MAN_W-1:0];
        inex  = guard | sticky;
      end
`else
      exp_o = exp_n;
      man_o = man_t;
      inex  = |disc;
`endif
    end
    // Unsigned builds drop the (always zero) sign bit here.
    pack_c = OUT_W'({s2.sign, exp_o, man_o});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1          <= '0;
      s2          <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_inexact <= 1'b0;
    end else begin
      if (rdy1) s1 <= s1_nxt;
      if (rdy2) s2 <= s2_nxt;
      if (rdy3) begin
        out_valid <= s2.valid;
        if (s2.valid) begin
          out_data    <= pack_c;
          out_inexact <= inex;
        end
      end
    end
  end

endmodule
